// File: rtl/mul8u_acc_stage.sv
// Accumulates a stream of 16-bit products into one ACC_W-bit sum and presents it over valid/ready.
// Optional macro BIAS_COMP_EN adds the BIAS constant to every accepted product.
module mul8u_acc_stage #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned LEN   = 16,
  parameter logic [15:0] BIAS  = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      prod,
  input  logic             prod_valid,
  input  logic             prod_last,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_data,
  output logic [7:0]       acc_count,
  output logic             acc_ovf,
  output logic             acc_valid,
  input  logic             acc_ready
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_cnt;
  logic             r_ovf;

  logic [ACC_W-1:0] w_addend;
  logic             w_addend_carry;
  logic [ACC_W:0]   w_sum;
  logic             w_ovf_nxt;
  logic             w_prod_hs;
  logic             w_res_hs;
  logic             w_close;

`ifdef BIAS_COMP_EN
  logic [ACC_W:0] w_biased;
  assign w_biased       = (ACC_W+1)'(prod) + (ACC_W+1)'(BIAS);
  assign w_addend       = w_biased[ACC_W-1:0];
  assign w_addend_carry = w_biased[ACC_W];
`else
  logic w_unused_bias;
  assign w_unused_bias  = ^BIAS;
  assign w_addend       = ACC_W'(prod);
  assign w_addend_carry = 1'b0;
`endif

  assign w_sum     = {1'b0, r_acc} + {1'b0, w_addend};
  assign w_ovf_nxt = r_ovf | w_sum[ACC_W] | w_addend_carry;

  // prod_ready is forced low during reset even though the state already reads ACCUM
  assign prod_ready = (r_state == ST_ACCUM) & ~rst;
  assign acc_valid  = (r_state == ST_HOLD);
  assign w_prod_hs  = prod_valid & prod_ready;
  assign w_res_hs   = acc_valid & acc_ready;
  assign w_close    = prod_last | (r_cnt == 8'(LEN - 1));

  // The running registers double as the result registers: they are frozen while in HOLD
  assign acc_data  = r_acc;
  assign acc_count = r_cnt;
  assign acc_ovf   = r_ovf;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM: if (w_prod_hs && w_close) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (w_res_hs)             w_state_nxt = ST_ACCUM;
      default:                            w_state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_prod_hs) begin
        r_acc <= w_sum[ACC_W-1:0];
        r_cnt <= r_cnt + 8'd1;
        r_ovf <= w_ovf_nxt;
      end else if (w_res_hs) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mul8u_acc_stage.md
Name: mul8u_acc_stage

Overview:
- Downstream consumer of the 8x8 unsigned approximate multipliers in the library.
- Accepts a stream of 16-bit products over a valid/ready handshake and accumulates LEN products, or fewer if terminated early by a last flag, into one ACC_W-bit sum.
- Presents the sum on a valid/ready output port.
- Used to run dot-product and MAC workloads on the approximate multipliers and to measure how their error accumulates.

Parameters:
- ACC_W, 24, accumulator and result width in bits; legal range 16..32.
- LEN, 16, maximum products per result; legal range 1..255.
- BIAS, 16'h0000, unsigned per-product error-compensation constant; used only when BIAS_COMP_EN is defined.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- prod  input  16  product from the multiplier (O[15:0]).
- prod_valid  input  1  prod is valid this cycle.
- prod_last  input  1  qualifies prod; this product closes the current sum.
- prod_ready  output  1  block accepts prod this cycle.
- acc_data  output  ACC_W  accumulated sum.
- acc_count  output  8  number of products contained in acc_data.
- acc_ovf  output  1  sum wrapped at least once.
- acc_valid  output  1  acc_data/acc_count/acc_ovf valid.
- acc_ready  input  1  downstream accepts result.

Behaviour:
- Reset (async, rst=1):
  - State goes to ACCUM.
  - Accumulator, count and overflow flag clear to 0.
  - acc_valid=0, acc_data=0, acc_count=0, acc_ovf=0, prod_ready=0 while rst is high.
  - A reset mid-sum or while holding a result discards it; nothing is emitted.
- FSM states: ACCUM, HOLD.
- ACCUM:
  - prod_ready=1, acc_valid=0.
  - Handshake is prod_valid & prod_ready.
  - On handshake: acc <= acc + zero-extend(prod) modulo 2^ACC_W; cnt <= cnt+1; ovf <= ovf | carry-out.
  - Transition to HOLD on a handshake where prod_last=1 or cnt==LEN-1 (LEN-th product).
  - When entering HOLD, acc_data, acc_count and acc_ovf load the updated values (including the final product).
- HOLD:
  - prod_ready=0, acc_valid=1.
  - Outputs stay stable until acc_valid & acc_ready.
  - On that handshake: clear acc, cnt and ovf, return to ACCUM.
  - acc_valid drops in the following cycle.
  - acc_ready is ignored outside HOLD.
- Latency: acc_valid rises the cycle after the closing product is accepted.
- Throughput: one product per cycle within a sum; one bubble cycle per result (HOLD) even if acc_ready is held high.
- prod and prod_last are sampled only on a handshake; prod_valid without ready has no effect.
- LEN=1: every accepted product produces a result; prod_last is redundant.
- prod_last=1 on the LEN-th product closes the sum once (no empty result).
- prod=0 still counts toward acc_count.
- Overflow: wrap-around arithmetic; acc_ovf is sticky within one sum and cleared per result.

Optional Feature:
- Macro: BIAS_COMP_EN.
- Defined: each accepted product adds (prod + BIAS), computed in ACC_W bits. Carry from either addition sets ovf. This compensates mean error of the approximate multipliers.
- Undefined: BIAS is ignored and no bias adder is built; behaviour is exactly as described above.

Test Plan:
- ACC_W=24, LEN=16, 16 back-to-back products of 16'hFFFF, acc_ready=1 -> one result: acc_data=24'h0FFFF0, acc_count=16, acc_ovf=0, acc_valid high exactly 1 cycle, asserted the cycle after the 16th handshake.
- LEN=16, products 100, 200, 300 with prod_last on the 3rd -> acc_data=600, acc_count=3; the next sum starts from 0.
- Hold acc_ready=0 for 5 cycles in HOLD with prod_valid=1 -> prod_ready=0 and outputs unchanged for all 5 cycles; release -> handshake, then ACCUM resumes.
- ACC_W=16, products 16'hFFFF then 16'h0002 with prod_last -> acc_data=16'h0001, acc_ovf=1; the following sum of a single 5 reports acc_ovf=0, acc_data=5.
- Assert rst for 1 cycle after 5 accepted products -> all outputs 0 immediately; next 2 products of 7 with prod_last give acc_data=14, acc_count=2.
- BIAS_COMP_EN defined, BIAS=16'h0100, LEN=4, four products of 0 -> acc_data=16'h0400, acc_count=4.
